frame_mean_feeder: RTL
======================

# frame_mean_feeder

Upstream stage of the unsigned divider in the averaging path. It accumulates a frame of unsigned samples, closes the frame on `sample_last`, and issues `dividend = frame sum` and `divisor = sample count` to the divider over its valid/ready handshake. It holds those operands stable until the divider reports completion, so only one division is in flight at a time.

## Interface
- `DWIDTH`, default 8: sample, sum, count and divider operand width.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ce`  in  1  clock enable, shared with the divider; when low, all state is frozen and no handshake completes.
- `sample_valid`  in  1  upstream sample present.
- `sample_ready`  out  1  feeder accepts a sample.
- `sample_data`  in  DWIDTH  unsigned sample.
- `sample_last`  in  1  qualifies the final sample of a frame.
- `div_valid`  out  1  to divider `input_data_valid`.
- `div_ready`  in  1  from divider `input_ready_for_data`.
- `div_dividend`  out  DWIDTH  frame sum, saturated.
- `div_divisor`  out  DWIDTH  frame sample count, saturated; never 0 while `div_valid` or WAIT.
- `div_done`  in  1  from divider `output_data_valid`.
- `sat_flag`  out  1  current or last-issued frame saturated its sum or its count.

## Operation
- States: ACCUM, ISSUE, WAIT.
- `sample_ready = (state == ACCUM)`; combinational from the state register.
- A sample is accepted when `ce & sample_valid & sample_ready`.
- Sum update, on accept: `sum_next = min(sum + sample_data, 2^DWIDTH-1)`. Compute at DWIDTH+1 bits, then clamp.
- Count update, on accept: `cnt_next = min(cnt + 1, 2^DWIDTH-1)`.
- Either clamp sets the saturation flag for the frame.
- ACCUM, non-last accept: `sum <= sum_next`, `cnt <= cnt_next`.
- ACCUM, last accept:
  - `div_dividend <= sum_next` and `div_divisor <= cnt_next`.
  - `sat_flag <= frame flag` (including this sample).
  - Clear `sum`, `cnt` and the frame flag; go to ISSUE.
- ISSUE: `div_valid = 1`. On `ce & div_ready`, go to WAIT and drop `div_valid` on the same edge.
- WAIT: `div_valid = 0`. On `ce & div_done`, go to ACCUM.
- `div_done` is ignored in ACCUM and ISSUE.
- `div_dividend` and `div_divisor` must not change from ISSUE entry until WAIT exit. The divider reads `dividend` live during its computation, so this hold is mandatory.
- `sat_flag` holds from frame issue until the next frame's first accepted sample, then clears.
- Illegal state encoding → ACCUM.

## Timing
- Reset values:
  - state = ACCUM, so `sample_ready = 1`.
  - `div_valid = 0`, `div_dividend = 0`, `div_divisor = 0`, `sat_flag = 0`.
  - `sum = 0`, `cnt = 0`.
- Reset takes priority over `ce`.
- Reset in any state, including WAIT, abandons the frame and the in-flight issue. The divider is reset by the same `rst`.
- Last sample accepted at edge N → `div_valid` high from edge N, registered, and `sample_ready` low from edge N.
- `div_valid` is held until the edge where `ce & div_ready`. Minimum ISSUE dwell is 1 cycle.
- `sample_ready` returns high on the edge that samples `div_done`.
- Throughput: one frame per (frame length + ISSUE dwell + divider latency + 1) cycles.
- `ce` low on any edge: no accept, no state change, outputs held.

## Structure
- Shared package holds:
  - State localparams ACCUM=2'b00, ISSUE=2'b01, WAIT=2'b10. The same encoding width as the divider FSM.
  - The `DWIDTH` default.
- One natural sub-module, `sat_add`: parameterised DWIDTH, adds a and b and outputs the clamped sum plus a `sat` bit. It is instantiated twice, once for sum and once for count (b = 1).
- Everything else lives inline in `frame_mean_feeder`.

## Test plan
All cases use DWIDTH=8 with the divider attached.

- Frame 10, 20, 30(last), `ce` = 1 → `div_dividend` = 60, `div_divisor` = 3, `sat_flag` = 0; divider quotient 20, remainder 0; `sample_ready` high the cycle after `div_done`.
- Frame 200, 100(last) → `div_dividend` = 255, `div_divisor` = 2, `sat_flag` = 1. Next frame 5(last) → 5/1, with `sat_flag` clearing on that frame's accept.
- 300 samples of value 0, last on the 300th → `div_divisor` = 255, `sat_flag` = 1, `div_dividend` = 0.
- Hold `div_ready` low for 5 cycles in ISSUE while driving `sample_valid` = 1 → `div_valid` held, operands constant, `sample_ready` = 0, no sample accepted.
- Toggle `ce` every other cycle over frame 7, 9(last) → same result 16/2, with every transition only on `ce`-high edges.
- Assert `rst` for 1 cycle in WAIT → next cycle `sample_ready` = 1, `div_valid` = 0. Following frame 4, 4(last) → 8/2.

Source files
------------

// File: rtl/frame_mean_feeder_pkg.sv
// Shared constants for the averaging-path feeder: default operand width and
// the 2-bit state encoding it shares with the downstream divider FSM.
package frame_mean_feeder_pkg;

  localparam int DWIDTH_DEF = 8;

  localparam logic [1:0] ACCUM = 2'b00;
  localparam logic [1:0] ISSUE = 2'b01;
  localparam logic [1:0] WAIT  = 2'b10;

endpackage

// File: rtl/frame_mean_feeder_sat.sv
// Saturating unsigned adder: a + b clamped to all-ones, with a flag that
// reports when the clamp was applied.
module sat_add #(
  parameter int DWIDTH = 8
) (
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic [DWIDTH-1:0] y,
  output logic              sat
);

  logic [DWIDTH:0] wide;

  always_comb begin
    wide = {1'b0, a} + {1'b0, b};
    sat  = wide[DWIDTH];
    y    = sat ? '1 : wide[DWIDTH-1:0];
  end

endmodule

// File: rtl/frame_mean_feeder.sv
// Accumulates a frame of unsigned samples and hands sum/count to the divider,
// holding the operands until the divider reports the result.
module frame_mean_feeder
  import frame_mean_feeder_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [DWIDTH-1:0] sample_data,
  input  logic              sample_last,
  output logic              div_valid,
  input  logic              div_ready,
  output logic [DWIDTH-1:0] div_dividend,
  output logic [DWIDTH-1:0] div_divisor,
  input  logic              div_done,
  output logic              sat_flag
);

  localparam logic [DWIDTH-1:0] ONE = {{(DWIDTH-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [DWIDTH-1:0] sum_q, sum_d;
  logic [DWIDTH-1:0] cnt_q, cnt_d;
  logic              frame_sat_q, frame_sat_d;
  logic [DWIDTH-1:0] dividend_q, dividend_d;
  logic [DWIDTH-1:0] divisor_q, divisor_d;
  logic              sat_flag_q, sat_flag_d;

  logic [DWIDTH-1:0] sum_next, cnt_next;
  logic              sum_sat, cnt_sat;
  logic              accept;
  logic              frame_sat_next;

  sat_add #(.DWIDTH(DWIDTH)) u_sum_add (
    .a   (sum_q),
    .b   (sample_data),
    .y   (sum_next),
    .sat (sum_sat)
  );

  sat_add #(.DWIDTH(DWIDTH)) u_cnt_add (
    .a   (cnt_q),
    .b   (ONE),
    .y   (cnt_next),
    .sat (cnt_sat)
  );

  assign sample_ready   = (state_q == ACCUM);
  assign div_valid      = (state_q == ISSUE);
  assign accept         = ce & sample_valid & sample_ready;
  assign frame_sat_next = frame_sat_q | sum_sat | cnt_sat;

  always_comb begin
    // NOTE: every _d starts as its _q so no path leaves a variable unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    frame_sat_d = frame_sat_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    sat_flag_d  = sat_flag_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          // sat_flag tracks the open frame from its first sample onward
          sat_flag_d = frame_sat_next;
          if (sample_last) begin
            dividend_d  = sum_next;
            divisor_d   = cnt_next;
            sum_d       = '0;
            cnt_d       = '0;
            frame_sat_d = 1'b0;
            state_d     = ISSUE;
          end else begin
            sum_d       = sum_next;
            cnt_d       = cnt_next;
            frame_sat_d = frame_sat_next;
          end
        end
      end
      ISSUE: if (ce && div_ready) state_d = WAIT;
      WAIT:  if (ce && div_done)  state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      sum_q       <= '0;
      cnt_q       <= '0;
      frame_sat_q <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      sat_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      frame_sat_q <= frame_sat_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      sat_flag_q  <= sat_flag_d;
    end
  end

  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign sat_flag     = sat_flag_q;

endmodule
